// File: rtl/emulib_dmamodel_pkg.sv
// Shared encodings for the DMA-model AXI4 memory responder: burst types,
// response codes, FSM state enums and the transfer-size clamp helper.
package emulib_dmamodel_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Transfers wider than the data bus behave as full-bus transfers.
  function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/emulib_dmamodel_burst_addr.sv
// Next-beat address generator for AXI4 FIXED / INCR / WRAP bursts.
// Reserved burst encoding advances like INCR.
module emulib_dmamodel_burst_addr
  import emulib_dmamodel_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    // Wrap window is (len+1) beats of 2^size bytes, aligned to its own size.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/emulib_dmamodel_mem_responder.sv
// AXI4 slave memory responder for the DMA model's target_dma_axi port, with
// independent read and write FSMs. Define DMAMODEL_RESP_ERR_EN for SLVERR on out-of-range beats.
module emulib_dmamodel_mem_responder
  import emulib_dmamodel_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    target_dma_axi_awvalid,
  output logic                    target_dma_axi_awready,
  input  logic [ID_WIDTH-1:0]     target_dma_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   target_dma_axi_awaddr,
  input  logic [7:0]              target_dma_axi_awlen,
  input  logic [2:0]              target_dma_axi_awsize,
  input  logic [1:0]              target_dma_axi_awburst,
  input  logic [2:0]              target_dma_axi_awprot,

  input  logic                    target_dma_axi_wvalid,
  output logic                    target_dma_axi_wready,
  input  logic [DATA_WIDTH-1:0]   target_dma_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] target_dma_axi_wstrb,
  input  logic                    target_dma_axi_wlast,

  output logic                    target_dma_axi_bvalid,
  input  logic                    target_dma_axi_bready,
  output logic [ID_WIDTH-1:0]     target_dma_axi_bid,
  output logic [1:0]              target_dma_axi_bresp,

  input  logic                    target_dma_axi_arvalid,
  output logic                    target_dma_axi_arready,
  input  logic [ID_WIDTH-1:0]     target_dma_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   target_dma_axi_araddr,
  input  logic [7:0]              target_dma_axi_arlen,
  input  logic [2:0]              target_dma_axi_arsize,
  input  logic [1:0]              target_dma_axi_arburst,
  input  logic [2:0]              target_dma_axi_arprot,

  output logic                    target_dma_axi_rvalid,
  input  logic                    target_dma_axi_rready,
  output logic [ID_WIDTH-1:0]     target_dma_axi_rid,
  output logic [DATA_WIDTH-1:0]   target_dma_axi_rdata,
  output logic [1:0]              target_dma_axi_rresp,
  output logic                    target_dma_axi_rlast
);

  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam int         B          = $clog2(STRB_WIDTH);
  localparam logic [2:0] MAX_SIZE   = 3'(B);
  localparam int         MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
`ifdef DMAMODEL_RESP_ERR_EN
  localparam bit         ERR_EN     = 1'b1;
`else
  localparam bit         ERR_EN     = 1'b0;
`endif

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return ERR_EN && ((a >> (MEM_DEPTH_LOG2 + B)) != '0);
  endfunction

  // Protection and wlast carry no meaning for this memory model.
  logic unused_inputs;
  assign unused_inputs = ^{target_dma_axi_awprot, target_dma_axi_arprot, target_dma_axi_wlast};

  // ---------------- write path ----------------
  wr_state_e             w_state_reg, w_state_next;
  logic [ID_WIDTH-1:0]   wid_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [7:0]            wlen_reg, wbeat_reg;
  logic [2:0]            wsize_reg;
  logic [1:0]            wburst_reg, bresp_reg;
  logic                  aw_hs, w_hs, mem_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state_reg <= W_IDLE;
    else     w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next           = w_state_reg;
    target_dma_axi_awready = 1'b0;
    target_dma_axi_wready  = 1'b0;
    target_dma_axi_bvalid  = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        target_dma_axi_awready = 1'b1;
        if (target_dma_axi_awvalid) w_state_next = W_DATA;
      end
      W_DATA: begin
        target_dma_axi_wready = 1'b1;
        if (target_dma_axi_wvalid && (wbeat_reg == wlen_reg)) w_state_next = W_RESP;
      end
      W_RESP: begin
        target_dma_axi_bvalid = 1'b1;
        if (target_dma_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign aw_hs  = target_dma_axi_awvalid && target_dma_axi_awready;
  assign w_hs   = target_dma_axi_wvalid && target_dma_axi_wready;
  assign mem_we = w_hs && !out_of_range(waddr_reg);

  emulib_dmamodel_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
    .addr      (waddr_reg),
    .size      (wsize_reg),
    .len       (wlen_reg),
    .burst     (wburst_reg),
    .next_addr (waddr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wid_reg    <= '0;
      waddr_reg  <= '0;
      wlen_reg   <= '0;
      wsize_reg  <= '0;
      wburst_reg <= BURST_INCR;
      wbeat_reg  <= '0;
      bresp_reg  <= RESP_OKAY;
    end else if (aw_hs) begin
      wid_reg    <= target_dma_axi_awid;
      waddr_reg  <= target_dma_axi_awaddr;
      wlen_reg   <= target_dma_axi_awlen;
      wsize_reg  <= clamp_size(target_dma_axi_awsize, MAX_SIZE);
      wburst_reg <= target_dma_axi_awburst;
      wbeat_reg  <= '0;
      bresp_reg  <= RESP_OKAY;
    end else if (w_hs) begin
      waddr_reg <= waddr_next;
      wbeat_reg <= wbeat_reg + 8'd1;
      // Error is sticky so one bad beat poisons the whole burst's response.
      if (out_of_range(waddr_reg)) bresp_reg <= RESP_SLVERR;
    end
  end

  assign target_dma_axi_bid   = wid_reg;
  assign target_dma_axi_bresp = bresp_reg;

  // ---------------- read path ----------------
  rd_state_e             r_state_reg, r_state_next;
  logic [ID_WIDTH-1:0]   rid_reg;
  logic [ADDR_WIDTH-1:0] raddr_reg, raddr_next, rd_load_addr;
  logic [7:0]            rlen_reg, rbeat_reg;
  logic [2:0]            rsize_reg;
  logic [1:0]            rburst_reg, rresp_reg;
  logic                  rlast_reg, ar_hs, r_hs, rd_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state_reg <= R_IDLE;
    else     r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next           = r_state_reg;
    target_dma_axi_arready = 1'b0;
    target_dma_axi_rvalid  = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        target_dma_axi_arready = 1'b1;
        if (target_dma_axi_arvalid) r_state_next = R_DATA;
      end
      R_DATA: begin
        target_dma_axi_rvalid = 1'b1;
        if (target_dma_axi_rready && rlast_reg) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign ar_hs = target_dma_axi_arvalid && target_dma_axi_arready;
  assign r_hs  = target_dma_axi_rvalid && target_dma_axi_rready;
  // The next beat is fetched on the handshake that retires the current one,
  // so the presented beat stays frozen while the master stalls.
  assign rd_load      = ar_hs || (r_hs && !rlast_reg);
  assign rd_load_addr = ar_hs ? target_dma_axi_araddr : raddr_next;

  emulib_dmamodel_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
    .addr      (raddr_reg),
    .size      (rsize_reg),
    .len       (rlen_reg),
    .burst     (rburst_reg),
    .next_addr (raddr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rid_reg    <= '0;
      raddr_reg  <= '0;
      rlen_reg   <= '0;
      rsize_reg  <= '0;
      rburst_reg <= BURST_INCR;
      rbeat_reg  <= '0;
      rlast_reg  <= 1'b0;
      rresp_reg  <= RESP_OKAY;
    end else if (ar_hs) begin
      rid_reg    <= target_dma_axi_arid;
      raddr_reg  <= target_dma_axi_araddr;
      rlen_reg   <= target_dma_axi_arlen;
      rsize_reg  <= clamp_size(target_dma_axi_arsize, MAX_SIZE);
      rburst_reg <= target_dma_axi_arburst;
      rbeat_reg  <= '0;
      rlast_reg  <= (target_dma_axi_arlen == 8'd0);
      rresp_reg  <= out_of_range(rd_load_addr) ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      if (rlast_reg) begin
        rlast_reg <= 1'b0;
        rresp_reg <= RESP_OKAY;
      end else begin
        raddr_reg <= raddr_next;
        rbeat_reg <= rbeat_reg + 8'd1;
        rlast_reg <= ((rbeat_reg + 8'd1) == rlen_reg);
        rresp_reg <= out_of_range(rd_load_addr) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ---------------- backing store ----------------
  logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]     wmask, mem_q_reg;
  logic [MEM_DEPTH_LOG2-1:0] wr_idx, rd_idx;

  assign wr_idx = waddr_reg[MEM_DEPTH_LOG2+B-1:B];
  assign rd_idx = rd_load_addr[MEM_DEPTH_LOG2+B-1:B];

  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
    assign wmask[gi*8 +: 8] = {8{target_dma_axi_wstrb[gi]}};
  end

  // Read samples the array before this edge's write lands: same-word
  // collisions return old data.
  always_ff @(posedge clk) begin
    if (mem_we)  mem[wr_idx] <= (mem[wr_idx] & ~wmask) | (target_dma_axi_wdata & wmask);
    if (rd_load) mem_q_reg   <= mem[rd_idx];
  end

  assign target_dma_axi_rid   = rid_reg;
  assign target_dma_axi_rdata = (rresp_reg == RESP_SLVERR) ? '0 : mem_q_reg;
  assign target_dma_axi_rresp = rresp_reg;
  assign target_dma_axi_rlast = rlast_reg;

endmodule
